// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute sequencer driving the ALU datapath controls
// Control word is registered: it reflects the state held during the previous cycle.
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALU_Flags,
    output logic        Halted,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel
);
    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [4:0] ALU_PASSB = 5'h01;
    localparam logic [4:0] ALU_ADD   = 5'h04;
    localparam logic [4:0] ALU_SUB   = 5'h06;
    localparam logic [4:0] ALU_AND   = 5'h07;
    localparam logic [4:0] ALU_OR    = 5'h08;
    localparam logic [1:0] PC_SEL    = 2'b00;
    localparam logic [1:0] AR_SEL    = 2'b10;

    localparam logic [2:0] S_FETCH_L = 3'd0;
    localparam logic [2:0] S_FETCH_H = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXEC1   = 3'd3;
    localparam logic [2:0] S_EXEC2   = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [5:0] OP_LDI = 6'h01;
    localparam logic [5:0] OP_LD  = 6'h02;
    localparam logic [5:0] OP_ST  = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h08;
    localparam logic [5:0] OP_BRA = 6'h09;
    localparam logic [5:0] OP_HLT = 6'h3F;

    typedef struct packed {
        logic       halted;
        logic [2:0] rf_outa_sel;
        logic [2:0] rf_outb_sel;
        logic [2:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] rf_scr_sel;
        logic [4:0] alu_fun_sel;
        logic       alu_wf;
        logic [1:0] arf_outc_sel;
        logic [1:0] arf_outd_sel;
        logic [2:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_cs;
        logic       mem_wr;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
    } ctrl_t;

    logic [2:0] state_q, state_d;
    logic [5:0] op_q, op_d;
    ctrl_t      ctrl_q, ctrl_d;

    wire [1:0] rx  = IROut[9:8];
    wire [2:0] dst = IROut[8:6];
    wire [2:0] s1  = IROut[5:3];
    wire [2:0] s2  = IROut[2:0];
    wire       is_alu_op = (op_q >= 6'h04) && (op_q <= 6'h07);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_FETCH_L;
            op_q          <= 6'h00;
            ctrl_q        <= '0;
            ctrl_q.mem_cs <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = S_FETCH_L;
        op_d    = op_q;
        case (state_q)
            S_FETCH_L: state_d = S_FETCH_H;
            S_FETCH_H: state_d = S_DECODE;
            S_DECODE: begin
                op_d    = IROut[15:10];
                state_d = (IROut[15:10] == OP_HLT) ? S_HALT : S_EXEC1;
            end
            S_EXEC1:   state_d = is_alu_op ? S_EXEC2 : S_FETCH_L;
            S_EXEC2:   state_d = S_FETCH_L;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH_L;
        endcase
    end

    always_comb begin
        ctrl_d        = '0;
        ctrl_d.mem_cs = 1'b1;
        case (state_q)
            S_FETCH_L, S_FETCH_H: begin
                ctrl_d.arf_outc_sel = PC_SEL;
                ctrl_d.mem_cs       = 1'b0;
                ctrl_d.ir_write     = 1'b1;
                ctrl_d.ir_lh        = (state_q == S_FETCH_H);
                ctrl_d.arf_reg_sel  = 3'b001 << PC_SEL;
                ctrl_d.arf_fun_sel  = FUN_INC;
            end
            S_EXEC1: begin
                if (op_q == OP_LDI) begin
                    ctrl_d.mux_a_sel  = 2'b10;
                    ctrl_d.rf_fun_sel = FUN_LOAD;
                    ctrl_d.rf_reg_sel = 4'b0001 << rx;
                end else if (op_q == OP_LD) begin
                    ctrl_d.arf_outc_sel = AR_SEL;
                    ctrl_d.mem_cs       = 1'b0;
                    ctrl_d.mux_a_sel    = 2'b11;
                    ctrl_d.rf_fun_sel   = FUN_LOAD;
                    ctrl_d.rf_reg_sel   = 4'b0001 << rx;
                end else if (op_q == OP_ST) begin
                    ctrl_d.rf_outb_sel  = {1'b0, rx};
                    ctrl_d.mux_c_sel    = 1'b0;
                    ctrl_d.alu_fun_sel  = ALU_PASSB;
                    ctrl_d.arf_outc_sel = AR_SEL;
                    ctrl_d.mem_cs       = 1'b0;
                    ctrl_d.mem_wr       = 1'b1;
                end else if (is_alu_op) begin
                    // first operand is passed through the ALU and staged via MuxC
                    ctrl_d.rf_outb_sel = s1;
                    ctrl_d.alu_fun_sel = ALU_PASSB;
                end else if ((op_q == OP_BRA) || ((op_q == OP_BEQ) && ALU_Flags[3])) begin
                    ctrl_d.mux_b_sel   = 2'b10;
                    ctrl_d.arf_fun_sel = FUN_LOAD;
                    ctrl_d.arf_reg_sel = 3'b001 << PC_SEL;
                end
            end
            S_EXEC2: begin
                ctrl_d.rf_outb_sel = s2;
                ctrl_d.mux_c_sel   = 1'b0;
                ctrl_d.alu_wf      = 1'b1;
                ctrl_d.mux_a_sel   = 2'b00;
                ctrl_d.rf_fun_sel  = FUN_LOAD;
                case (op_q[1:0])
                    2'd0:    ctrl_d.alu_fun_sel = ALU_ADD;
                    2'd1:    ctrl_d.alu_fun_sel = ALU_SUB;
                    2'd2:    ctrl_d.alu_fun_sel = ALU_AND;
                    default: ctrl_d.alu_fun_sel = ALU_OR;
                endcase
                // DST codes 4-7 address the scratch registers
                if (dst[2]) ctrl_d.rf_scr_sel = 4'b0001 << dst[1:0];
                else        ctrl_d.rf_reg_sel = 4'b0001 << dst[1:0];
            end
            S_HALT:  ctrl_d.halted = 1'b1;
            default: ;
        endcase
    end

    assign Halted      = ctrl_q.halted;
    assign RF_OutASel  = ctrl_q.rf_outa_sel;
    assign RF_OutBSel  = ctrl_q.rf_outb_sel;
    assign RF_FunSel   = ctrl_q.rf_fun_sel;
    assign RF_RegSel   = ctrl_q.rf_reg_sel;
    assign RF_ScrSel   = ctrl_q.rf_scr_sel;
    assign ALU_FunSel  = ctrl_q.alu_fun_sel;
    assign ALU_WF      = ctrl_q.alu_wf;
    assign ARF_OutCSel = ctrl_q.arf_outc_sel;
    assign ARF_OutDSel = ctrl_q.arf_outd_sel;
    assign ARF_FunSel  = ctrl_q.arf_fun_sel;
    assign ARF_RegSel  = ctrl_q.arf_reg_sel;
    assign IR_LH       = ctrl_q.ir_lh;
    assign IR_Write    = ctrl_q.ir_write;
    assign Mem_CS      = ctrl_q.mem_cs;
    assign Mem_WR      = ctrl_q.mem_wr;
    assign MuxASel     = ctrl_q.mux_a_sel;
    assign MuxBSel     = ctrl_q.mux_b_sel;
    assign MuxCSel     = ctrl_q.mux_c_sel;
endmodule
